// File: rtl/aes_req_scheduler_if.sv
// Host/core handshake bundle for aes_req_scheduler.
// master drives requests and core ready lines; slave is the scheduler.
interface aes_req_scheduler_if;
  logic [1:0] req;
  logic [1:0] op0;
  logic [1:0] op1;
  logic       key_inval;
  logic       keyexprdy;
  logic       encdecrdy;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [1:0] err;
  logic       keyexp;
  logic       staenc;
  logic       stadec;
  logic       busy;
  logic       key_valid;

  modport master (
    output req, op0, op1, key_inval, keyexprdy, encdecrdy,
    input  gnt, done, err, keyexp, staenc, stadec, busy, key_valid
  );

  modport slave (
    input  req, op0, op1, key_inval, keyexprdy, encdecrdy,
    output gnt, done, err, keyexp, staenc, stadec, busy, key_valid
  );
endinterface

// File: rtl/aes_req_scheduler.sv
// Two-port round-robin scheduler in front of a shared AES core with key-validity tracking.
// Optional macro AES_SCHED_AUTOKEY_EN: insert key expansion before enc/dec when the key is stale.
module aes_req_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 6
) (
  input  logic              clk,
  input  logic              rst,
  aes_req_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

  localparam logic [1:0]       OP_ILL   = 2'b00;
  localparam logic [1:0]       OP_KEY   = 2'b01;
  localparam logic [1:0]       OP_ENC   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             win;
  logic             rr_last;
  logic             err_f;
  logic             phase_ke;
  logic             fire;
  logic             auto_f;
  logic [1:0]       op;
  logic [CNT_W-1:0] cnt;

  logic       w_c;
  logic [1:0] w_op_c;
  logic [1:0] w_oh_c;
  logic [1:0] win_oh;
  logic       rdy_both;
  logic       rdy_sel;
  logic       auto_c;
  logic       nokey_c;

  // Contention goes to the port that was not served last.
  assign w_c      = (bus.req == 2'b11) ? ~rr_last : bus.req[1];
  assign w_op_c   = w_c ? bus.op1 : bus.op0;
  assign w_oh_c   = w_c ? 2'b10 : 2'b01;
  assign win_oh   = win ? 2'b10 : 2'b01;
  assign rdy_both = bus.keyexprdy & bus.encdecrdy;
  assign rdy_sel  = phase_ke ? bus.keyexprdy : bus.encdecrdy;

`ifdef AES_SCHED_AUTOKEY_EN
  assign auto_c  = w_op_c[1] & ~bus.key_valid;
  assign nokey_c = 1'b0;
`else
  assign auto_c  = 1'b0;
  assign nokey_c = w_op_c[1] & ~bus.key_valid;
  assign auto_f  = 1'b0;
`endif

  // {keyexp, staenc, stadec} for the op about to be started.
  function automatic logic [2:0] start_vec(input logic [1:0] o, input logic ke);
    if (ke || o == OP_KEY) return 3'b100;
    else if (o == OP_ENC)  return 3'b010;
    else                   return 3'b001;
  endfunction

  // The start pulse is registered: 'fire' marks the ISSUE cycle in which it is on the wire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      win           <= 1'b0;
      rr_last       <= 1'b1;
      err_f         <= 1'b0;
      phase_ke      <= 1'b0;
      fire          <= 1'b0;
      op            <= OP_ILL;
      cnt           <= '0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.err       <= '0;
      bus.keyexp    <= 1'b0;
      bus.staenc    <= 1'b0;
      bus.stadec    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.key_valid <= 1'b0;
`ifdef AES_SCHED_AUTOKEY_EN
      auto_f        <= 1'b0;
`endif
    end else begin
      {bus.keyexp, bus.staenc, bus.stadec} <= 3'b000;
      bus.done <= '0;
      bus.err  <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win      <= w_c;
            op       <= w_op_c;
            bus.gnt  <= w_oh_c;
            bus.busy <= 1'b1;
            fire     <= 1'b0;
            phase_ke <= auto_c | (w_op_c == OP_KEY);
`ifdef AES_SCHED_AUTOKEY_EN
            auto_f   <= auto_c;
`endif
            if (w_op_c == OP_ILL) begin
              state    <= DONE;
              err_f    <= 1'b1;
              bus.done <= w_oh_c;
              bus.err  <= w_oh_c;
            end else begin
              state <= ISSUE;
              err_f <= nokey_c;
              if (!nokey_c && rdy_both) begin
                fire <= 1'b1;
                {bus.keyexp, bus.staenc, bus.stadec} <= start_vec(w_op_c, auto_c);
              end
            end
          end
        end
        ISSUE: begin
          if (err_f) begin
            state    <= DONE;
            bus.done <= win_oh;
            bus.err  <= win_oh;
          end else if (fire) begin
            state <= WAIT_LO;
            fire  <= 1'b0;
            cnt   <= '0;
          end else if (rdy_both) begin
            fire <= 1'b1;
            {bus.keyexp, bus.staenc, bus.stadec} <= start_vec(op, auto_f);
          end
        end
        WAIT_LO: begin
          if (!rdy_sel) begin
            state <= WAIT_HI;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            err_f    <= 1'b1;
            bus.done <= win_oh;
            bus.err  <= win_oh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (rdy_sel) begin
            if (phase_ke) bus.key_valid <= 1'b1;
            if (auto_f) begin
              state    <= ISSUE;
              phase_ke <= 1'b0;
`ifdef AES_SCHED_AUTOKEY_EN
              auto_f   <= 1'b0;
`endif
              if (rdy_both) begin
                fire <= 1'b1;
                {bus.keyexp, bus.staenc, bus.stadec} <= start_vec(op, 1'b0);
              end
            end else begin
              state    <= DONE;
              bus.done <= win_oh;
            end
          end else if (cnt == CNT_LAST) begin
            state    <= DONE;
            err_f    <= 1'b1;
            bus.done <= win_oh;
            bus.err  <= win_oh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          rr_last  <= win;
        end
        default: state <= IDLE;
      endcase
      // A fresh host key always wins over a completing expansion.
      if (bus.key_inval) bus.key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Scoreboard bench for aes_req_scheduler with an 11-cycle-busy AES core model.
module tb_aes_req_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  aes_req_scheduler_if bus();

  aes_req_scheduler #(.TIMEOUT_CYCLES(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: each start pulse makes its ready line low for 11 cycles; 'hang' freezes enc/dec.
  int ke_cnt, ed_cnt;
  bit hang = 1'b0;
  bit ed_hung;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ke_cnt  <= 0;
      ed_cnt  <= 0;
      ed_hung <= 1'b0;
    end else begin
      if (ke_cnt > 0) ke_cnt <= ke_cnt - 1;
      else if (bus.keyexp) ke_cnt <= 11;
      if (ed_cnt > 0) ed_cnt <= ed_cnt - 1;
      else if (bus.staenc || bus.stadec) begin
        if (hang) ed_hung <= 1'b1;
        else      ed_cnt  <= 11;
      end
      if (!hang) ed_hung <= 1'b0;
    end
  end
  assign bus.keyexprdy = (ke_cnt == 0);
  assign bus.encdecrdy = (ed_cnt == 0) && !ed_hung;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    int port; int err; int lat; int ke; int enc; int dec;
  } exp_t;
  exp_t sb[$];

  int t0 = 0;
  int ndone = 0;
  int ke_seen = -1, enc_seen = -1, dec_seen = -1;

  // Monitor: record start pulses, compare each done against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.keyexp && ke_seen < 0)  ke_seen  = cyc - t0;
      if (bus.staenc && enc_seen < 0) enc_seen = cyc - t0;
      if (bus.stadec && dec_seen < 0) dec_seen = cyc - t0;
      if (bus.done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_port", 32'(bus.done), (e.port == 1) ? 2 : 1);
          chk("gnt_at_done", 32'(bus.gnt), (e.port == 1) ? 2 : 1);
          chk("err", 32'(bus.err), e.err ? ((e.port == 1) ? 2 : 1) : 0);
          chk("latency", cyc - t0, e.lat);
          chk("keyexp_cycle", ke_seen, e.ke);
          chk("staenc_cycle", enc_seen, e.enc);
          chk("stadec_cycle", dec_seen, e.dec);
        end
        ke_seen = -1; enc_seen = -1; dec_seen = -1;
        ndone++;
      end
    end
  end

  function automatic int outs();
    return 32'({bus.gnt, bus.done, bus.err, bus.keyexp, bus.staenc, bus.stadec,
                bus.busy, bus.key_valid});
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset_outputs", outs(), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Drive one request, wait for its done (bounded), then release req in the following IDLE cycle.
  task automatic run_op(input int port, input logic [1:0] op, input int err_e, input int lat,
                        input int ke, input int enc, input int dec, input int inval_at);
    int target;
    @(posedge clk); #1;
    sb.push_back('{port, err_e, lat, ke, enc, dec});
    t0 = cyc;
    ke_seen = -1; enc_seen = -1; dec_seen = -1;
    target = ndone + 1;
    if (port == 0) bus.op0 = op; else bus.op1 = op;
    bus.req = (port == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < 100 && ndone < target; i++) begin
      @(posedge clk); #1;
      bus.key_inval = (inval_at >= 0) && (cyc - t0 == inval_at);
    end
    bus.key_inval = 1'b0;
    if (ndone < target) begin
      chk("done_timeout", ndone, target);
      sb.delete();
    end
    bus.req = 2'b00;
  endtask

  initial begin
    int target;
    bus.req = 2'b00; bus.op0 = 2'b00; bus.op1 = 2'b00; bus.key_inval = 1'b0;
    rst = 1'b1;
    #3;
    do_reset();
    chk("kv_after_reset", 32'(bus.key_valid), 0);

    // key expansion, then enc and dec with a valid key
    run_op(0, 2'b01, 0, 14, 1, -1, -1, -1);
    chk("kv_after_keyexp", 32'(bus.key_valid), 1);
    run_op(1, 2'b10, 0, 14, -1, 1, -1, -1);
    run_op(0, 2'b11, 0, 14, -1, -1, 1, -1);
    chk("kv_kept", 32'(bus.key_valid), 1);

    // key_inval clears key_valid on the next cycle
    @(posedge clk); #1 bus.key_inval = 1'b1;
    @(posedge clk); #1 bus.key_inval = 1'b0;
    chk("kv_after_inval", 32'(bus.key_valid), 0);

    // decrypt with stale key
`ifdef AES_SCHED_AUTOKEY_EN
    run_op(0, 2'b11, 0, 27, 1, -1, 14, -1);
    chk("kv_after_auto", 32'(bus.key_valid), 1);
`else
    run_op(0, 2'b11, 1, 2, -1, -1, -1, -1);
    chk("kv_after_nokey", 32'(bus.key_valid), 0);
`endif

    // illegal opcode
    run_op(0, 2'b00, 1, 1, -1, -1, -1, -1);

    // key_inval coincident with key expansion completion
    run_op(1, 2'b01, 0, 14, 1, -1, -1, 13);
    chk("kv_inval_priority", 32'(bus.key_valid), 0);

    // enc/dec timeout in WAIT_HI
    run_op(0, 2'b01, 0, 14, 1, -1, -1, -1);
    hang = 1'b1;
    run_op(1, 2'b10, 1, 35, -1, 1, -1, -1);
    hang = 1'b0;
    chk("kv_after_timeout", 32'(bus.key_valid), 1);

    // round robin with both ports requesting continuously
    @(posedge clk); #1;
    do_reset();
    chk("kv_after_reset2", 32'(bus.key_valid), 0);
    run_op(1, 2'b01, 0, 14, 1, -1, -1, -1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 0, 14 + 15 * i, -1, 1 + 15 * i, -1});
    t0 = cyc;
    ke_seen = -1; enc_seen = -1; dec_seen = -1;
    target = ndone + 4;
    bus.op0 = 2'b10; bus.op1 = 2'b10; bus.req = 2'b11;
    for (int i = 0; i < 200 && ndone < target; i++) begin
      @(posedge clk); #1;
    end
    bus.req = 2'b00;
    if (ndone < target) begin
      chk("rr_timeout", ndone, target);
      sb.delete();
    end

    // asynchronous reset in the middle of WAIT_HI
    @(posedge clk); #1;
    bus.op0 = 2'b10; bus.req = 2'b01;
    repeat (6) @(posedge clk);
    #2;
    chk("busy_before_rst", 32'(bus.busy), 1);
    chk("kv_before_rst", 32'(bus.key_valid), 1);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    bus.req = 2'b00;
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_rst", outs(), 0);
    chk("no_stray_done", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Shares one aescontrol-based AES core between two requesters (host port 0, host port 1).
- Round-robin arbitration between the two ports.
- Issues single-cycle keyexp/staenc/stadec start pulses and waits for the core's ready handshake.
- Tracks whether the expanded key is current, inserts key expansion before enc/dec when it is not, and reports done/err per requester.

Parameters:
- TIMEOUT_CYCLES, 32, max cycles in WAIT_HI before the op is aborted with err.
- CNT_W, 6, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- req  in  2  per-port request; held high until done[i].
- op0  in  2  port 0 opcode: 01 keyexp, 10 encrypt, 11 decrypt, 00 illegal.
- op1  in  2  port 1 opcode, same encoding.
- key_inval  in  1  pulse: host loaded a new cipher key; expanded key is stale.
- keyexprdy  in  1  from core; 1 = key expansion idle.
- encdecrdy  in  1  from core; 1 = enc/dec idle.
- gnt  out  2  one-hot grant; held from ISSUE through DONE.
- done  out  2  one-cycle completion pulse for the granted port.
- err  out  2  one-cycle pulse coincident with done on failure.
- keyexp  out  1  one-cycle start pulse to core.
- staenc  out  1  one-cycle start pulse to core.
- stadec  out  1  one-cycle start pulse to core.
- busy  out  1  1 whenever state != IDLE.
- key_valid  out  1  expanded key is current.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, any time, including mid-operation):
  - state=IDLE; gnt, done, err, keyexp, staenc, stadec, busy, key_valid = 0; rr pointer favours port 0.
  - The core is reset separately; a pending request is not resumed after reset.
- All outputs are registered or Moore decodes of state; no input-to-output combinational path.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
- IDLE:
  - If any req is high, pick the winner: the single requester, or on contention the port not last served.
  - Latch the winner's opcode. Set auto flag = (op is enc/dec) && !key_valid. Go to ISSUE.
  - Illegal op 00: go directly to DONE with err set.
- ISSUE:
  - gnt[winner]=1. Stall while (keyexprdy & encdecrdy)==0.
  - Otherwise assert exactly one start pulse for one cycle and go to WAIT_LO: keyexp if auto flag or op=01, else staenc (10) or stadec (11).
- WAIT_LO:
  - Wait for the selected rdy (keyexprdy for key expansion, encdecrdy otherwise) to read 0 → WAIT_HI, clear timeout counter.
  - If rdy is still 1 after 2 cycles in WAIT_LO → DONE with err.
- WAIT_HI:
  - Counter increments each cycle. When the selected rdy reads 1:
    - after a key expansion: key_valid set; if auto flag, clear auto flag and return to ISSUE for the real op; else go to DONE.
    - after enc/dec: go to DONE.
  - Counter reaching TIMEOUT_CYCLES → DONE with err; key_valid unchanged.
- DONE:
  - done[winner]=1 for one cycle; err[winner]=1 if the error flag is set.
  - Update rr pointer to the winner. gnt drops the next cycle; return to IDLE.
- key_inval:
  - Clears key_valid the next cycle. Takes priority over a simultaneous set.
  - Arriving mid-operation, it does not abort the current op.
- Latency with the core's 11-cycle busy window (ISSUE = cycle 1 after req sampled in cycle 0):
  - enc/dec, key valid: done at cycle 14.
  - auto-key then enc/dec: done at cycle 27.
- Back-to-back: a req held after done is not re-arbitrated until IDLE (minimum 1 idle cycle between grants).

Optional Feature:
- Macro AES_SCHED_AUTOKEY_EN.
- Defined: automatic key-expansion insertion as described above.
- Undefined: enc/dec requested while key_valid=0 goes IDLE→DONE with err, no start pulse issued; the auto flag logic is not present.

Test Plan:
- Reset then req=01, op0=01 → keyexp pulse at cycle 1, keyexprdy low cycles 2-12, done[0] at cycle 14, key_valid=1, err=0.
- key_valid=1, req=10, op1=10 → staenc pulse at cycle 1, gnt=10 cycles 1-14, done[1] at cycle 14; stadec and keyexp stay 0.
- key_valid=0, req=01, op0=11 with AES_SCHED_AUTOKEY_EN → keyexp at cycle 1, stadec at cycle 14, done[0] at cycle 27. Without the macro → err[0]+done[0] at cycle 2, no pulses.
- req=11 held continuously, ops=10 → grants alternate 01,10,01 after reset; no port is starved; done pulses never overlap.
- Core model holds encdecrdy=0 forever after staenc → err pulse at WAIT_HI+TIMEOUT_CYCLES (cycle 35 with default). Also: op0=00 → err[0] at cycle 1.
- rst driven low mid-WAIT_HI asynchronously → all outputs 0 immediately, key_valid=0. key_inval coincident with keyexp completion → key_valid stays 0.
